// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM states, grant IDs
// and the round-robin pick rule used by rr_arb2.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RD   = 2'd2
  } state_t;

  localparam logic GNT_CPU     = 1'b0;
  localparam logic GNT_DBG     = 1'b1;
  localparam int   NUM_MASTERS = 2;

  // On a tie the master that did not win last time goes first; a lone
  // requester always wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    logic pick;
    if (req0 && req1) begin
      pick = ~last;
    end else if (req1) begin
      pick = GNT_DBG;
    end else begin
      pick = GNT_CPU;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin decision over a single last-grant bit; purely combinational.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt
);

  assign gnt = rr_pick(req0, req1, last);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU and a debug master onto one single-port synchronous RAM.
// Each access runs IDLE -> ACC -> RD and finishes with a one-cycle ack pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_wen,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic [WIDTH-1:0]     cpu_wdata,
  output logic                 cpu_ack,
  output logic [WIDTH-1:0]     cpu_rdata,
  input  logic                 dbg_req,
  input  logic                 dbg_wen,
  input  logic [ADDR_SIZE-1:0] dbg_addr,
  input  logic [WIDTH-1:0]     dbg_wdata,
  output logic                 dbg_ack,
  output logic [WIDTH-1:0]     dbg_rdata,
  output logic                 ram_cs,
  output logic                 ram_wen,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WIDTH-1:0]     ram_din,
  input  logic [WIDTH-1:0]     ram_dout
);

  state_t                 state_reg, state_next;
  logic                   last_reg;
  logic                   win_reg;
  logic                   wen_reg;
  logic [ADDR_SIZE-1:0]   addr_reg;
  logic [WIDTH-1:0]       wdata_reg;
  logic                   gnt;
  logic                   grant_en;
  logic                   rd_done;
  logic                   any_ack;

  logic [NUM_MASTERS-1:0] ack_reg;
  logic [WIDTH-1:0]       rdata_reg [NUM_MASTERS];

  rr_arb2 u_rr_arb2 (
    .req0 (cpu_req),
    .req1 (dbg_req),
    .last (last_reg),
    .gnt  (gnt)
  );

  // An ack still on the wire blocks a new grant, giving the master a cycle to drop req.
  assign any_ack = |ack_reg;

  always_comb begin
    state_next = state_reg;
    grant_en   = 1'b0;
    rd_done    = 1'b0;
    ram_cs     = 1'b0;
    ram_wen    = 1'b0;
    case (state_reg)
      IDLE: begin
        if ((cpu_req || dbg_req) && !any_ack) begin
          grant_en   = 1'b1;
          state_next = ACC;
        end
      end
      ACC: begin
        ram_cs     = 1'b1;
        ram_wen    = wen_reg;
        state_next = RD;
      end
      RD: begin
        rd_done    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ram_addr = addr_reg;
  assign ram_din  = wdata_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      last_reg  <= GNT_DBG;
      win_reg   <= GNT_CPU;
      wen_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_en) begin
        win_reg   <= gnt;
        last_reg  <= gnt;
        wen_reg   <= (gnt == GNT_DBG) ? dbg_wen   : cpu_wen;
        addr_reg  <= (gnt == GNT_DBG) ? dbg_addr  : cpu_addr;
        wdata_reg <= (gnt == GNT_DBG) ? dbg_wdata : cpu_wdata;
      end
    end
  end

  // Per-master completion: ack pulses for one cycle, rdata only moves on reads.
  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      always_ff @(posedge clk) begin
        if (reset) begin
          ack_reg[gi]   <= 1'b0;
          rdata_reg[gi] <= '0;
        end else begin
          ack_reg[gi] <= rd_done && (win_reg == 1'(gi));
          if (rd_done && (win_reg == 1'(gi)) && !wen_reg) begin
            rdata_reg[gi] <= ram_dout;
          end
        end
      end
    end
  endgenerate

  assign cpu_ack   = ack_reg[GNT_CPU];
  assign dbg_ack   = ack_reg[GNT_DBG];
  assign cpu_rdata = rdata_reg[GNT_CPU];
  assign dbg_rdata = rdata_reg[GNT_DBG];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, transaction-level reference model,
// a table of isolated accesses, directed corner sequences and random traffic.
module tb_mem_arbiter;

  localparam int W = 32;
  localparam int A = 16;

  typedef struct {
    bit           m;
    bit           wen;
    logic [A-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] exp_rdata;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req;
  logic [1:0]   wen;
  logic [A-1:0] addr [2];
  logic [W-1:0] wdata [2];
  logic         cpu_ack, dbg_ack;
  logic [W-1:0] cpu_rdata, dbg_rdata;
  logic         ram_cs, ram_wen;
  logic [A-1:0] ram_addr;
  logic [W-1:0] ram_din, ram_dout;
  logic [1:0]   ackv;

  bit   [W-1:0] mem [0:65535];
  logic         bd_we;
  logic [A-1:0] bd_addr;
  logic [W-1:0] bd_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: one outstanding access described by its grant cycle.
  int           nf;
  int           g_cyc;
  bit           last_m;
  bit           g_who;
  bit           g_wen;
  logic [A-1:0] g_addr;
  logic [W-1:0] g_wdata;
  logic [W-1:0] g_rd;
  logic [W-1:0] m_rd [2];
  bit   [W-1:0] mmem [0:65535];

  vec_t vecs [8];
  bit   hold [2];

  assign ackv = {dbg_ack, cpu_ack};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (ram_cs) begin
      if (ram_wen) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  mem_arbiter #(.WIDTH(W), .ADDR_SIZE(A)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (req[0]),
    .cpu_wen   (wen[0]),
    .cpu_addr  (addr[0]),
    .cpu_wdata (wdata[0]),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (req[1]),
    .dbg_wen   (wen[1]),
    .dbg_addr  (addr[1]),
    .dbg_wdata (wdata[1]),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .ram_cs    (ram_cs),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  function automatic void chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %b expected %b", name, cyc, act, exp);
    end
  endfunction

  function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  // Applies the edge that ends cycle cyc, using the inputs driven during it.
  function automatic void model_edge();
    if (reset) begin
      nf      = cyc + 1;
      last_m  = 1'b1;
      g_cyc   = -100;
      m_rd[0] = '0;
      m_rd[1] = '0;
    end else if (cyc >= nf && (req[0] || req[1])) begin
      if (req[0] && req[1]) g_who = ~last_m;
      else                  g_who = req[1];
      last_m  = g_who;
      g_cyc   = cyc;
      nf      = cyc + 4;
      g_wen   = wen[g_who];
      g_addr  = addr[g_who];
      g_wdata = wdata[g_who];
      if (g_wen) mmem[g_addr] = g_wdata;
      else       g_rd = mmem[g_addr];
    end
  endfunction

  function automatic void check_cycle();
    bit cs_e;
    bit ack_e;
    cs_e  = (cyc == g_cyc + 1);
    ack_e = (cyc == g_cyc + 3);
    if (ack_e && !g_wen) m_rd[g_who] = g_rd;
    chk1("ram_cs", ram_cs, cs_e);
    chk1("ram_wen", ram_wen, cs_e && g_wen);
    if (cs_e) begin
      chk32("ram_addr", 32'(ram_addr), 32'(g_addr));
      if (g_wen) chk32("ram_din", ram_din, g_wdata);
    end
    chk1("cpu_ack", cpu_ack, ack_e && !g_who);
    chk1("dbg_ack", dbg_ack, ack_e && g_who);
    chk32("cpu_rdata", cpu_rdata, m_rd[0]);
    chk32("dbg_rdata", dbg_rdata, m_rd[1]);
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    cyc++;
    #1;
    check_cycle();
  endtask

  task automatic single_access(input vec_t v);
    int c0, cs_c, ack_c;
    req[v.m]   = 1'b1;
    wen[v.m]   = v.wen;
    addr[v.m]  = v.addr;
    wdata[v.m] = v.wdata;
    c0    = cyc;
    cs_c  = -1;
    ack_c = -1;
    for (int k = 0; k < 10 && ack_c < 0; k++) begin
      tick();
      if (ram_cs && cs_c < 0) begin
        cs_c = cyc;
        chk1("tv_wen", ram_wen, v.wen);
        chk32("tv_addr", 32'(ram_addr), 32'(v.addr));
        if (v.wen) chk32("tv_din", ram_din, v.wdata);
      end
      if (ackv[v.m]) ack_c = cyc;
    end
    chk32("tv_cs_latency", 32'(cs_c), 32'(c0 + 1));
    chk32("tv_ack_latency", 32'(ack_c), 32'(c0 + 3));
    chk32("tv_rdata", v.m ? dbg_rdata : cpu_rdata, v.exp_rdata);
    chk1("tv_other_ack", ackv[~v.m], 1'b0);
    $display("access m=%0d wen=%0d addr=%h wdata=%h rdata=%h cs@%0d ack@%0d start@%0d",
             v.m, v.wen, v.addr, v.wdata, v.m ? dbg_rdata : cpu_rdata, cs_c, ack_c, c0);
    tick();
    req[v.m] = 1'b0;
    tick();
  endtask

  initial begin
    int q_who [$];
    int q_cyc [$];
    int both;
    int a;
    int cnt;
    int first;

    reset = 1'b1;
    req   = '0;
    wen   = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i]  = '0;
      wdata[i] = '0;
      hold[i]  = 1'b0;
    end
    nf     = 0;
    g_cyc  = -100;
    last_m = 1'b1;
    g_who  = 1'b0;
    g_wen  = 1'b0;
    bd_we  = 1'b1;
    bd_addr = 16'h0010;
    bd_data = 32'hDEADBEEF;
    mmem[16'h0010] = 32'hDEADBEEF;
    tick();
    bd_we = 1'b0;
    tick();
    chk1("reset_cs", ram_cs, 1'b0);
    chk32("reset_cpu_rdata", cpu_rdata, 32'h0);
    reset = 1'b0;
    tick();

    vecs[0] = '{1'b0, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 16'h0020, 32'h12345678, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 16'h0020, 32'h0,        32'h12345678};
    vecs[3] = '{1'b1, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b1, 16'h0030, 32'hA5A5A5A5, 32'h12345678};
    vecs[5] = '{1'b1, 1'b0, 16'h0030, 32'h0,        32'hA5A5A5A5};
    vecs[6] = '{1'b0, 1'b1, 16'hFFFF, 32'hCAFEF00D, 32'h12345678};
    vecs[7] = '{1'b1, 1'b0, 16'hFFFF, 32'h0,        32'hCAFEF00D};
    for (int i = 0; i < 8; i++) single_access(vecs[i]);

    // Both masters request continuously from reset: strict alternation, CPU first.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wen = 2'b00;
    addr[0] = 16'h0010;
    addr[1] = 16'h0020;
    req = 2'b11;
    both = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (cpu_ack && dbg_ack) both++;
      if (cpu_ack) begin q_who.push_back(0); q_cyc.push_back(cyc); end
      if (dbg_ack) begin q_who.push_back(1); q_cyc.push_back(cyc); end
    end
    chk1("rr_enough_acks", q_who.size() >= 4, 1'b1);
    chk32("rr_overlap", 32'(both), 32'h0);
    for (int i = 0; i < 4 && i < q_who.size(); i++) begin
      chk32("rr_order", 32'(q_who[i]), 32'(i % 2));
      if (i > 0) chk32("rr_spacing", 32'(q_cyc[i] - q_cyc[i-1]), 32'd4);
      $display("rr ack %0d master=%0d cycle=%0d", i, q_who[i], q_cyc[i]);
    end
    req = 2'b00;
    tick();
    tick();
    tick();
    tick();

    // CPU holds req through its ack cycle; DBG asks during that cycle.
    wen = 2'b00;
    addr[0] = 16'h0010;
    req[0] = 1'b1;
    a = -1;
    for (int k = 0; k < 10 && a < 0; k++) begin
      tick();
      if (cpu_ack) a = cyc;
    end
    chk1("hold_ack_seen", a >= 0, 1'b1);
    addr[1] = 16'h0020;
    req[1] = 1'b1;
    tick();
    chk1("hold_no_dup_cs", ram_cs, 1'b0);
    req[0] = 1'b0;
    tick();
    chk1("hold_next_cs", ram_cs, 1'b1);
    chk32("hold_next_addr", 32'(ram_addr), 32'h0020);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (cpu_ack) cnt++;
      if (dbg_ack) req[1] = 1'b0;
    end
    chk32("hold_no_dup_ack", 32'(cnt), 32'h0);
    $display("hold ack@%0d dbg cs@%0d extra_cpu_acks=%0d", a, a + 2, cnt);
    req = 2'b00;
    tick();

    // Reset lands on the ACC cycle of a CPU read.
    addr[0] = 16'h0010;
    req[0] = 1'b1;
    tick();
    chk1("abort_in_acc", ram_cs, 1'b1);
    reset = 1'b1;
    req[0] = 1'b0;
    tick();
    reset = 1'b0;
    chk1("abort_cs", ram_cs, 1'b0);
    chk1("abort_ack", cpu_ack, 1'b0);
    chk32("abort_rdata", cpu_rdata, 32'h0);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (cpu_ack) cnt++;
    end
    chk32("abort_no_late_ack", 32'(cnt), 32'h0);
    addr[0] = 16'h0020;
    addr[1] = 16'h0010;
    req = 2'b11;
    first = -1;
    for (int k = 0; k < 8 && first < 0; k++) begin
      tick();
      if (cpu_ack) first = 0;
      else if (dbg_ack) first = 1;
    end
    chk32("abort_tie_winner", 32'(first), 32'h0);
    $display("abort tie winner=%0d", first);
    req = 2'b00;
    tick();
    tick();
    tick();
    tick();

    // Random traffic: masters hold req one cycle past ack, occasional resets.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int m = 0; m < 2; m++) begin
        if (req[m] && ackv[m]) begin
          hold[m] = 1'b1;
        end else if (hold[m]) begin
          req[m]  = 1'b0;
          hold[m] = 1'b0;
        end else if (!req[m] && $urandom_range(0, 2) == 0) begin
          req[m]   = 1'b1;
          wen[m]   = 1'($urandom_range(0, 1));
          addr[m]  = A'($urandom_range(0, 15));
          wdata[m] = $urandom;
        end
      end
      tick();
      if (cpu_ack || dbg_ack)
        $display("rand cycle=%0d cpu_ack=%0d dbg_ack=%0d cpu_rdata=%h dbg_rdata=%h",
                 cyc, cpu_ack, dbg_ack, cpu_rdata, dbg_rdata);
    end
    reset = 1'b0;
    req = 2'b00;
    for (int k = 0; k < 6; k++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits.
REQ-002 Parameter ADDR_SIZE, default 16: word address width in bits.
REQ-003 Port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 Port reset  in  1  reset, synchronous and active-high.
REQ-005 Ports cpu_req/dbg_req  in  1 each  access request; held high until the matching ack.
REQ-006 Ports cpu_wen/dbg_wen  in  1 each  1 = write, 0 = read; stable while req is high.
REQ-007 Ports cpu_addr/dbg_addr  in  ADDR_SIZE each  word address.
REQ-008 Ports cpu_wdata/dbg_wdata  in  WIDTH each  write data.
REQ-009 Ports cpu_ack/dbg_ack  out  1 each  one-cycle completion pulse.
REQ-010 Ports cpu_rdata/dbg_rdata  out  WIDTH each  registered read data, valid while ack is high, held afterwards.
REQ-011 Port ram_cs  out  1  RAM chip select.
REQ-012 Port ram_wen  out  1  RAM write enable.
REQ-013 Port ram_addr  out  ADDR_SIZE  RAM address.
REQ-014 Port ram_din  out  WIDTH  RAM write data.
REQ-015 Port ram_dout  in  WIDTH  RAM read data; valid one cycle after ram_cs.

Function
REQ-016 FSM states SHALL be IDLE, ACC and RD.
REQ-017 IDLE: a pending request, with both acks low, SHALL trigger these actions at the edge:
- latch the winner's wen, addr and wdata;
- record the winner;
- go to ACC.
REQ-018 IDLE SHALL grant nothing in any cycle where cpu_ack or dbg_ack is high; this gives the master one cycle to drop req.
REQ-019 ACC: ram_cs SHALL be 1, decoded from state; ram_wen, ram_addr and ram_din SHALL come from the latched values; next state RD.
REQ-020 RD: ram_cs SHALL be 0. At the edge, the winner's rdata SHALL load ram_dout on reads, the winner's ack SHALL be set for the next cycle, and the next state SHALL be IDLE.
REQ-021 On writes, rdata SHALL be left unchanged; ack timing SHALL be identical to reads.
REQ-022 Latency: req sampled at edge N SHALL give ram_cs high in cycle N+1 and ack high in cycle N+3; peak rate is one access per 4 cycles.
REQ-023 Arbitration SHALL be round-robin over a last-grant bit. On simultaneous requests the master not granted last SHALL win; a lone request SHALL always win.
REQ-024 Outside ACC, ram_cs and ram_wen SHALL be 0.
REQ-025 Each ack SHALL be high for exactly one cycle per access; the two acks SHALL never be high together.
REQ-026 A request dropped before its ack is a protocol violation. The access already granted SHALL still complete and ack SHALL still pulse.

Reset
REQ-027 While reset is high at an edge, the block SHALL set the following:
- state IDLE;
- cpu_ack and dbg_ack 0;
- cpu_rdata and dbg_rdata 0;
- latched wen, addr and wdata 0;
- last-grant = DBG, so that CPU wins the first tie.
REQ-028 Reset asserted in ACC or RD SHALL abort the access: no ack pulse, ram_cs 0 from the next cycle.

Structure
REQ-029 State encodings (IDLE=0, ACC=1, RD=2) and grant IDs (GNT_CPU=0, GNT_DBG=1) SHALL live in the shared defs include.
REQ-030 The round-robin decision SHALL be a sub-module rr_arb2 with these signals:
- inputs: req0, req1, last;
- output: gnt (combinational).

Verification
REQ-031 CPU read only, addr 0x0010 preloaded 0xDEADBEEF:
- ram_cs high in cycle N+1;
- cpu_ack high in cycle N+3 with cpu_rdata = 0xDEADBEEF;
- dbg_ack stays 0.
REQ-032 DBG write: addr 0x0020, data 0x12345678, then a CPU read of 0x0020.
- Write: ram_wen=1 with that address and data for one cycle, then dbg_ack.
- Read: cpu_rdata = 0x12345678.
REQ-033 Both reqs held high continuously after reset:
- grants alternate CPU, DBG, CPU, DBG;
- acks appear 4 cycles apart;
- the two acks never coincide.
REQ-034 Req kept high one cycle past its ack: no duplicate grant (REQ-018), and the next access starts only after the idle cycle.
REQ-035 Reset pulsed during ACC of a CPU read: no cpu_ack, ram_cs 0 afterwards, rdata 0, and the next tie goes to CPU.
